// File: rtl/imem_prog_loader_pkg.sv
// Shared types and defaults for the instruction-memory program loader.
//   state_e      : loader FSM states
//   DefaultAddrW : default instruction-memory word-address width
package imem_prog_loader_pkg;

    localparam int unsigned DefaultAddrW = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a stream of bytes into big-endian 32-bit words.
//   clk, rst     : clock, async active-high reset
//   byte_i       : incoming byte
//   strobe_i     : byte_i is consumed this cycle
//   clear_i      : restart packing at byte index 0
//   word_o       : assembled word, valid together with word_valid_o
//   word_valid_o : this strobe completes a word (4th byte)
//   idx_o        : index of the next byte within the word (0..3)
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        strobe_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic [1:0]  idx_o
);

    // Only the first three bytes need storing; the fourth is taken live from byte_i.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (strobe_i) begin
            shift_d = {shift_q[15:0], byte_i};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign word_o       = {shift_q, byte_i};
    assign word_valid_o = strobe_i && !clear_i && (idx_q == 2'd3);
    assign idx_o        = idx_q;

endmodule

// File: rtl/imem_prog_loader.sv
// Loads the instruction memory from a length-prefixed, XOR-checksummed byte stream.
//   clk, rst           : clock, async active-high reset
//   start              : begin a load (honoured in idle/done/error only)
//   in_valid/in_data   : byte stream input, in_ready is the handshake reply
//   im_we/im_addr/im_wdata : instruction-memory write port
//   cpu_hold           : keeps the CPU in reset until a load succeeds
//   done/error         : outcome of the last load
//   words_loaded       : words written in the current/last load
module imem_prog_loader
    import imem_prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DefaultAddrW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic              accept;
    logic              pk_strobe;
    logic              pk_clear;
    logic [31:0]       pk_word;
    logic              pk_word_valid;
    logic [1:0]        pk_idx;
    logic [15:0]       len_rx;
    logic [ADDR_W:0]   words_inc;

    assign in_ready  = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCsum);
    assign accept    = in_valid && in_ready;
    assign pk_strobe = accept && (state_q == StData);
    assign len_rx    = {len_q[15:8], in_data};
    assign words_inc = words_q + 1'b1;

    byte_word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (in_data),
        .strobe_i     (pk_strobe),
        .clear_i      (pk_clear),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid),
        .idx_o        (pk_idx)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        xor_d      = xor_q;
        addr_d     = addr_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        error_d    = error_q;
        words_d    = words_q;
        pk_clear   = 1'b0;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLenHi;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    words_d    = '0;
                    xor_d      = '0;
                    addr_d     = '0;
                    pk_clear   = 1'b1;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d   = {in_data, len_q[7:0]};
                    xor_d   = xor_q ^ in_data;
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = len_rx;
                    xor_d = xor_q ^ in_data;
                    if ({1'b0, len_rx} > MaxWords) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else if (len_rx == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    xor_d = xor_q ^ in_data;
                    if (pk_word_valid) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = pk_word;
                        im_addr_d  = addr_q;
                        addr_d     = addr_q + 1'b1;
                        words_d    = words_inc;
                    end
                    // Final byte of the final word moves on to the checksum.
                    if ((pk_idx == 2'd3) && (16'(words_inc) == len_q)) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= '0;
            xor_q      <= '0;
            addr_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            xor_q      <= xor_d;
            addr_q     <= addr_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
            words_q    <= words_d;
        end
    end

    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: doc/imem_prog_loader.md
# imem_prog_loader

Hardware program loader that fills the MIPS instruction memory from a byte stream, replacing the simulation-only file preload. It accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and packs bytes into big-endian 32-bit words. It writes each word to consecutive instruction-memory word addresses and holds the CPU (`cpu_hold`) until a load completes with a correct checksum. It sits between the host link (UART/JTAG byte receiver) and the instruction memory's write port.

## Interface
- `ADDR_W`, 8, instruction-memory word-address width; capacity 2^ADDR_W words.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR; ignored otherwise.
- `in_valid`  input  1  byte on `in_data` is valid.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `im_we`  output  1  instruction-memory write strobe, one cycle per word.
- `im_addr`  output  ADDR_W  word address for the write.
- `im_wdata`  output  32  word to write.
- `cpu_hold`  output  1  hold CPU/PC in reset while high.
- `done`  output  1  level; last load succeeded.
- `error`  output  1  level; last load failed (length or checksum).
- `words_loaded`  output  ADDR_W+1  count of words written in the current/last load.

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4·N data bytes (first byte → bits 31:24), then one checksum byte equal to the XOR of every preceding byte of the stream, length bytes included.
- A byte transfers on a cycle with `in_valid && in_ready`. `in_ready` = 1 only in LEN_HI, LEN_LO, DATA and CSUM.
- States and transitions:
  - IDLE: `start` → LEN_HI. Entering LEN_HI sets `cpu_hold`=1 and clears `done`, `error`, `words_loaded`, the running XOR, the byte index and the word address.
  - LEN_HI: byte → LEN_LO.
  - LEN_LO: if N > 2^ADDR_W → ERR; else if N == 0 → CSUM; else → DATA.
  - DATA: byte index 0..3 shifts bytes into a 32-bit packer. On the 4th byte, `im_wdata`/`im_addr` are registered and `im_we` pulses next cycle. The word address then increments. After word N's 4th byte → CSUM.
  - CSUM: byte equal to running XOR → DONE; else → ERR.
  - DONE: `done`=1, `cpu_hold`=0; `start` → LEN_HI.
  - ERR: `error`=1, `cpu_hold`=1; `start` → LEN_HI.
- `start` in LEN_HI/LEN_LO/DATA/CSUM has no effect.
- Running XOR covers only accepted bytes; bubbles (`in_valid`=0) change nothing.
- Address never wraps: N ≤ 2^ADDR_W guarantees the last address is 2^ADDR_W−1.

## Timing
- Reset values: state IDLE, `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=0, `done`=0, `error`=0, `words_loaded`=0.
- Throughput: one byte per cycle; `in_ready` stays high across writes, so there is no back-pressure inside a load.
- Write latency: `im_we` is high exactly one cycle, the cycle after the 4th byte of a word is accepted. `words_loaded` increments in the same cycle as `im_we`.
- `done`/`error` and the `cpu_hold` release assert one cycle after the checksum byte is accepted.
- On the LEN_LO acceptance that leads to ERR, `in_ready` is low from the next cycle on.
- Async `rst` mid-load forces the reset values immediately, including `im_we`=0. A partially written memory is not cleared.

## Structure
- Package `imem_prog_loader_pkg`: state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR) and the default `ADDR_W`.
- One sub-module, `byte_word_packer`: shift register plus 2-bit byte index. Inputs are byte strobe and clear; outputs are `word`, a `word_valid` pulse and the index.
- Top level holds the FSM, XOR accumulator, address counter and output registers.

## Test plan
- Stream 00 02 20 08 00 05 8C 09 00 04 AE → writes addr0=20080005 and addr1=8C090004, one `im_we` cycle each; then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- Same stream with checksum AF → both words written, `error`=1, `done`=0, `cpu_hold`=1.
- Stream 00 00 00 (N=0) → no `im_we`, `done`=1, `words_loaded`=0.
- ADDR_W=8, stream 01 01 → ERR after the 2nd byte, `in_ready`=0, `error`=1, no writes.
- First stream with random 0–3 cycle `in_valid` gaps → identical writes and `done`; XOR unaffected by bubbles.
- `rst` pulse after the 6th byte → outputs at reset values immediately, state IDLE. A subsequent `start` plus full stream loads correctly.
